next_pc_unit: RTL and testbench

Generates the next_pc value consumed by Program_Counter. Implements SPARC-style delayed control transfer by holding the nPC register, so the instruction after a branch/call/jmpl (the delay slot) always executes unless annulled. Sits between decode/ALU condition logic and Program_Counter. Supports stall, trap redirect and boot sequencing.

---
 rtl/next_pc_unit.sv | 108 ++++++++++
 tb/tb_next_pc_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Next-PC generator with SPARC-style delayed control transfer: holds nPC so the
// delay-slot instruction runs before the target, with annul, stall, trap and boot.
module next_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter logic [31:0] INC          = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        trap,
  input  logic [31:0] pc_in,
  input  logic [1:0]  sel,
  input  logic        br_taken,
  input  logic        br_always,
  input  logic        annul_bit,
  input  logic [29:0] disp30,
  input  logic [21:0] disp22,
  input  logic [31:0] jmpl_target,
  output logic [31:0] next_pc,
  output logic        annul,
  output logic        align_err
);

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_CALL = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;

  // BOOT and TRAP are one-cycle fixups that load base+INC before normal sequencing.
  typedef enum logic [1:0] {BOOT, TRAP, RUN} state_t;

  state_t      state_r, state_d;
  logic [31:0] npc_r, npc_d;
  logic        annul_r, annul_d;
  logic        align_r, align_d;

  logic [31:0] call_target;
  logic [31:0] br_target;
  logic        br_go;

  assign call_target = pc_in + {disp30, 2'b00};
  assign br_target   = pc_in + {{8{disp22[21]}}, disp22, 2'b00};
  assign br_go       = br_taken | br_always;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= BOOT;
      npc_r   <= RESET_VECTOR;
      annul_r <= 1'b0;
      align_r <= 1'b0;
    end else begin
      state_r <= state_d;
      npc_r   <= npc_d;
      annul_r <= annul_d;
      align_r <= align_d;
    end
  end

  always_comb begin
    state_d = state_r;
    npc_d   = npc_r;
    annul_d = annul_r;
    align_d = 1'b0;
    if (trap) begin
      state_d = TRAP;
      npc_d   = TRAP_VECTOR;
      annul_d = 1'b0;
    end else if (!stall) begin
      unique case (state_r)
        BOOT: begin
          state_d = RUN;
          npc_d   = RESET_VECTOR + INC;
          annul_d = 1'b0;
        end
        TRAP: begin
          state_d = RUN;
          npc_d   = TRAP_VECTOR + INC;
          annul_d = 1'b0;
        end
        default: begin
          if (annul_r) begin
            // Squashed slot: its own control transfer must not take effect.
            npc_d   = npc_r + INC;
            annul_d = 1'b0;
          end else begin
            unique case (sel)
              SEL_SEQ:  npc_d = npc_r + INC;
              SEL_CALL: npc_d = call_target;
              SEL_BR: begin
                npc_d   = br_go ? br_target : (npc_r + INC);
                annul_d = annul_bit & (~br_taken | br_always);
              end
              default: begin
                npc_d   = {jmpl_target[31:2], 2'b00};
                align_d = |jmpl_target[1:0];
              end
            endcase
          end
        end
      endcase
    end
  end

  assign next_pc   = npc_r;
  assign annul     = annul_r;
  assign align_err = align_r;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios plus random stimulus
// compared against a behavioural model of the delayed-transfer rules.
module tb_next_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst, stall, trap, br_taken, br_always, annul_bit;
  logic [31:0] pc_in, jmpl_target;
  logic [1:0]  sel;
  logic [29:0] disp30;
  logic [21:0] disp22;
  logic [31:0] next_pc;
  logic        annul, align_err;

  int total = 0;
  int bad   = 0;

  // model state: pending fixup flag + base, nPC, annul, align pulse
  logic [31:0] m_npc;
  logic        m_annul, m_align, m_fix;
  logic [31:0] m_base;

  next_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .trap(trap), .pc_in(pc_in), .sel(sel),
    .br_taken(br_taken), .br_always(br_always), .annul_bit(annul_bit),
    .disp30(disp30), .disp22(disp22), .jmpl_target(jmpl_target),
    .next_pc(next_pc), .annul(annul), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply the architectural rules to the inputs present before the edge.
  task automatic model_step();
    logic [31:0] tgt;
    if (rst) begin
      m_npc = RV; m_annul = 0; m_align = 0; m_fix = 1; m_base = RV;
    end else if (trap) begin
      m_npc = TV; m_annul = 0; m_align = 0; m_fix = 1; m_base = TV;
    end else if (stall) begin
      m_align = 0;
    end else if (m_fix) begin
      m_npc = m_base + 32'd4; m_fix = 0; m_annul = 0; m_align = 0;
    end else if (m_annul) begin
      m_npc = m_npc + 32'd4; m_annul = 0; m_align = 0;
    end else begin
      m_align = 0;
      case (sel)
        2'd0: m_npc = m_npc + 32'd4;
        2'd1: m_npc = pc_in + 32'(disp30) * 32'd4;
        2'd2: begin
          tgt = pc_in + 32'($signed(disp22)) * 32'd4;
          if (br_taken || br_always) m_npc = tgt;
          else m_npc = m_npc + 32'd4;
          m_annul = annul_bit && (!br_taken || br_always);
        end
        default: begin
          m_npc   = jmpl_target & 32'hFFFF_FFFC;
          m_align = (jmpl_target % 4) != 0;
        end
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("next_pc", next_pc, m_npc);
    chk("annul", 32'(annul), 32'(m_annul));
    chk("align_err", 32'(align_err), 32'(m_align));
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; trap = 0; pc_in = '0; sel = 2'd0;
    br_taken = 0; br_always = 0; annul_bit = 0;
    disp30 = '0; disp22 = '0; jmpl_target = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_npc = '0; m_annul = 0; m_align = 0; m_fix = 1; m_base = RV;

    // reset then boot sequencing
    repeat (3) begin tick(); chk("rst_npc", next_pc, 32'h0); end
    rst = 0;
    tick(); chk("boot0", next_pc, 32'h4);
    tick(); chk("boot1", next_pc, 32'h8);
    tick(); chk("boot2", next_pc, 32'hC);
    tick(); chk("seq", next_pc, 32'h10);
    tick(); chk("seq", next_pc, 32'h14);

    // taken branch at 0x10, forward and backward displacement
    pc_in = 32'h10; sel = 2'd2; br_taken = 1; disp22 = 22'd3;
    tick(); chk("br_fwd", next_pc, 32'h1C);
    disp22 = 22'h3FFFFF;
    tick(); chk("br_back", next_pc, 32'hC);

    // not-taken annulling branch; slot's call is squashed
    sel = 2'd3; jmpl_target = 32'h24; br_taken = 0;
    tick(); chk("jmpl24", next_pc, 32'h24);
    pc_in = 32'h20; sel = 2'd2; annul_bit = 1;
    tick(); chk("nt_a_npc", next_pc, 32'h28); chk("nt_a_annul", 32'(annul), 32'h1);
    pc_in = 32'h24; sel = 2'd1; disp30 = 30'h100; annul_bit = 0;
    tick(); chk("squash_npc", next_pc, 32'h2C); chk("squash_annul", 32'(annul), 32'h0);
    pc_in = 32'h30; sel = 2'd2; br_always = 1; annul_bit = 1; disp22 = 22'd4;
    tick(); chk("ba_a_npc", next_pc, 32'h40); chk("ba_a_annul", 32'(annul), 32'h1);
    br_always = 0; annul_bit = 0; sel = 2'd0;
    tick();

    // call and misaligned jmpl
    pc_in = 32'h40; sel = 2'd1; disp30 = 30'h10;
    tick(); chk("call", next_pc, 32'h80);
    sel = 2'd3; jmpl_target = 32'h103;
    tick(); chk("jmpl_al", next_pc, 32'h100); chk("align_pulse", 32'(align_err), 32'h1);
    sel = 2'd0;
    tick(); chk("align_clear", 32'(align_err), 32'h0);

    // stall holds, trap beats stall, reset clears annul
    stall = 1;
    repeat (4) begin tick(); chk("stall_hold", next_pc, 32'h104); end
    trap = 1;
    tick(); chk("trap", next_pc, 32'h80);
    trap = 0; stall = 0;
    tick(); chk("trap_fix", next_pc, 32'h84);
    pc_in = 32'h84; sel = 2'd2; annul_bit = 1;
    tick(); chk("pre_rst_annul", 32'(annul), 32'h1);
    annul_bit = 0; sel = 2'd0; rst = 1;
    tick(); chk("rst_npc2", next_pc, 32'h0); chk("rst_annul", 32'(annul), 32'h0);
    rst = 0;
    tick();

    // wrap from 0xFFFF_FFFC to 0
    sel = 2'd3; jmpl_target = 32'hFFFF_FFFC;
    tick(); chk("wrap_pre", next_pc, 32'hFFFF_FFFC);
    sel = 2'd0;
    tick(); chk("wrap", next_pc, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(99) == 0);
      trap        = ($urandom_range(49) == 0);
      stall       = ($urandom_range(4) == 0);
      sel         = 2'($urandom_range(3));
      pc_in       = ($urandom_range(3) == 0) ? m_npc : $urandom;
      br_taken    = 1'($urandom_range(1));
      br_always   = ($urandom_range(3) == 0);
      annul_bit   = 1'($urandom_range(1));
      disp30      = 30'($urandom);
      disp22      = 22'($urandom);
      jmpl_target = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
